// File: rtl/grf_wb_pkg.sv
// Shared types and constants for the GRF write arbiter and its aux queue.
// The starvation guard is enabled with the GRF_WB_STARVE_EN macro.
package grf_wb_pkg;

    localparam int unsigned GRF_AW = 5;
    localparam int unsigned GRF_DW = 32;

    localparam logic [GRF_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [GRF_AW-1:0] rd;
        logic [GRF_DW-1:0] data;
        logic [31:0]       pc;
    } wb_entry_t;

    // One-hot register mask; $0 never maps to a bit.
    function automatic logic [(1<<GRF_AW)-1:0] reg_onehot(input logic [GRF_AW-1:0] r);
        logic [(1<<GRF_AW)-1:0] m;
        m = '0;
        if (r != REG_ZERO) begin
            m[r] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/grf_wb_fifo.sv
// Power-of-two FIFO of writeback entries with full/empty/count and a
// per-slot valid vector used to build the pending-register mask.
module grf_wb_fifo
    import grf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  wb_entry_t                push_entry_i,
    output wb_entry_t                head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [DEPTH-1:0]         valid_o,
    output wb_entry_t [DEPTH-1:0]    entries_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic                  do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        // Push and pop never address the same slot: push needs a free
        // slot, pop needs an occupied one.
        if (do_push) begin
            wr_ptr_d          = wr_ptr_q + 1'b1;
            valid_d[wr_ptr_q] = 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d          = rd_ptr_q + 1'b1;
            valid_d[rd_ptr_q] = 1'b0;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign valid_o   = valid_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/grf_write_arbiter.sv
// Sole owner of the GRF write port: pipeline writeback has priority, late aux
// results queue in a FIFO. Optional starvation guard: GRF_WB_STARVE_EN.
module grf_write_arbiter
    import grf_wb_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              PipeWrite,
    input  logic [GRF_AW-1:0] PipeReg,
    input  logic [GRF_DW-1:0] PipeData,
    input  logic [31:0]       PipePC,
    input  logic              AuxValid,
    output logic              AuxReady,
    input  logic [GRF_AW-1:0] AuxReg,
    input  logic [GRF_DW-1:0] AuxData,
    input  logic [31:0]       AuxPC,
    output logic              RegWrite,
    output logic [GRF_AW-1:0] WriteReg,
    output logic [GRF_DW-1:0] WriteData,
    output logic [31:0]       WPC,
    output logic [31:0]       Pending,
    output logic              PipeStall
);

    logic                  pipe_live;
    logic                  aux_push;
    logic                  q_pop;
    wb_entry_t             aux_entry;
    wb_entry_t             q_head;
    logic                  q_full, q_empty;
    logic [$clog2(DEPTH):0] q_count;
    logic [DEPTH-1:0]      q_valid;
    wb_entry_t [DEPTH-1:0] q_entries;
    logic                  unused_count;

    logic              wr_en_q,   wr_en_d;
    logic [GRF_AW-1:0] wr_reg_q,  wr_reg_d;
    logic [GRF_DW-1:0] wr_data_q, wr_data_d;
    logic [31:0]       wr_pc_q,   wr_pc_d;
    logic [31:0]       pending_mask;

    assign pipe_live = PipeWrite && (PipeReg != REG_ZERO);
    assign AuxReady  = ~q_full;
    // AuxReg == $0 is handshaken but never enters the queue.
    assign aux_push  = AuxValid && AuxReady && (AuxReg != REG_ZERO);
    assign q_pop     = ~pipe_live & ~q_empty;
    assign unused_count = ^q_count;

    assign aux_entry = '{rd: AuxReg, data: AuxData, pc: AuxPC};

    grf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (Clock),
        .rst_ni       (Reset),
        .push_i       (aux_push),
        .pop_i        (q_pop),
        .push_entry_i (aux_entry),
        .head_o       (q_head),
        .full_o       (q_full),
        .empty_o      (q_empty),
        .count_o      (q_count),
        .valid_o      (q_valid),
        .entries_o    (q_entries)
    );

    always_comb begin
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        wr_pc_d   = wr_pc_q;
        if (pipe_live) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = PipeReg;
            wr_data_d = PipeData;
            wr_pc_d   = PipePC;
        end else if (q_pop) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = q_head.rd;
            wr_data_d = q_head.data;
            wr_pc_d   = q_head.pc;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            wr_pc_q   <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            wr_pc_q   <= wr_pc_d;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (q_valid[i]) begin
                pending_mask = pending_mask | reg_onehot(q_entries[i].rd);
            end
        end
    end

    assign RegWrite  = wr_en_q;
    assign WriteReg  = wr_reg_q;
    assign WriteData = wr_data_q;
    assign WPC       = wr_pc_q;
    assign Pending   = pending_mask;

`ifdef GRF_WB_STARVE_EN
    localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);

    logic [SCW-1:0] starve_q, starve_d;
    logic           stall_q, stall_d;
    logic           blocked;

    assign blocked = pipe_live & ~q_empty;

    // Counter saturates at the limit so the stall fires exactly once per run.
    always_comb begin
        starve_d = starve_q;
        stall_d  = 1'b0;
        if (q_pop) begin
            starve_d = '0;
        end else if (blocked) begin
            if (starve_q == SCW'(STARVE_LIMIT - 1)) begin
                stall_d = 1'b1;
            end
            if (starve_q < SCW'(STARVE_LIMIT)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign PipeStall = stall_q;
`else
    localparam int unsigned UNUSED_STARVE_LIMIT = STARVE_LIMIT;
    assign PipeStall = 1'b0;
`endif

endmodule

// File: doc/grf_write_arbiter.md
# grf_write_arbiter

Single owner of the general register file write port. Merges the in-order writeback stream from the pipeline with late results from multi-cycle producers (multiply/divide, slow loads) through a small FIFO. Drives the GRF write port from registered outputs. Exports a per-register pending mask to the hazard unit.

## Interface
Parameters:
- DEPTH, 2: aux queue entries (power of two, ≥2)
- STARVE_LIMIT, 8: consecutive blocked cycles before a forced drain (only with starvation guard)

Ports:
- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-low; all state cleared while low
- PipeWrite  in  1  pipeline writeback request this cycle
- PipeReg  in  5  pipeline destination register
- PipeData  in  32  pipeline result
- PipePC  in  32  PC of the producing instruction
- AuxValid  in  1  aux result offered
- AuxReady  out  1  aux result accepted this edge when AuxValid is high
- AuxReg  in  5  aux destination register
- AuxData  in  32  aux result
- AuxPC  in  32  PC of the producing aux instruction
- RegWrite  out  1  GRF write enable
- WriteReg  out  5  GRF write address
- WriteData  out  32  GRF write data
- WPC  out  32  PC tagged to the GRF write
- Pending  out  32  bit r set while a queued aux entry targets register r
- PipeStall  out  1  pipeline must present PipeWrite=0 this cycle

## Operation
- Pipe request is live when PipeWrite=1 and PipeReg≠0. Pipe requests with PipeReg=0 are ignored.
- Aux accept: AuxValid & AuxReady. AuxReg=0 is accepted and dropped, not enqueued. AuxReady = queue not full, from registered count only; no enqueue into a full queue even if it drains the same edge.
- Arbitration each cycle: a live pipe request wins. Otherwise the queue head drains if the queue is non-empty. Otherwise the output is idle.
- The queue is a FIFO: head-first drain, pointers wrap modulo DEPTH. Enqueue and dequeue may happen on the same edge.
- Pending[r] = OR over valid queue entries with reg==r. A bit stays set until the last matching entry leaves the queue. Pending[0] is always 0.
- Ordering: the arbiter never reorders or cancels writes. The hazard unit stalls any instruction that reads or writes a register with Pending set.
- Output registers load the winning request {1, reg, data, pc}, or RegWrite=0 when idle. When RegWrite=0, WriteReg, WriteData and WPC hold their last values.

## Timing
- Reset values: RegWrite=0, WriteReg=0, WriteData=0, WPC=0, Pending=0, PipeStall=0, AuxReady=1, queue empty.
- Pipe request → RegWrite at the next edge. Latency 1 cycle; the GRF commits one edge later.
- Aux accept into an empty queue with no pipe request → head drains the next cycle → RegWrite one edge after that.
- Pending clears on the same edge the entry moves into the output registers. The GRF read bypass covers the read in the following cycle.
- Reset asserted mid-operation: queued entries are discarded and no write is emitted.

## Configuration
- GRF_WB_STARVE_EN defined: a counter counts cycles where the queue is non-empty and the head is blocked by a live pipe request.
  - At STARVE_LIMIT it raises registered PipeStall for exactly one cycle. The pipeline guarantees PipeWrite=0 in that cycle, so the head drains.
  - The counter clears on every drain and on reset.
- Undefined: PipeStall is tied 0, STARVE_LIMIT is unused, and the aux path can starve indefinitely.

## Structure
- Package grf_wb_pkg holds:
  - wb_entry_t {reg[4:0], data[31:0], pc[31:0]}
  - REG_ZERO
  - GRF_AW=5 and GRF_DW=32
- Sub-module grf_wb_fifo: parameterised DEPTH FIFO of wb_entry_t with full/empty/count and a per-entry valid vector for Pending generation.

## Test plan
- After reset: AuxReady=1, Pending=0, RegWrite=0. Hold Reset low for several edges with AuxValid=1; no state changes.
- Pipe write $5←0x1234 at PC 0x3000 → next cycle RegWrite=1, WriteReg=5, WriteData=0x00001234, WPC=0x00003000.
- Collision:
  - Stimulus: in one cycle, pipe writes $3←0xA and aux enqueues $4←0xB.
  - Cycle+1: output is $3 and Pending[4]=1.
  - Cycle+2: output is $4 and Pending[4]=0.
- Full queue:
  - Stimulus: enqueue $6 and $7 while pipe writes every cycle. AuxReady drops to 0.
  - The third AuxValid is held off; with pipe idle, outputs follow FIFO order $6 then $7.
  - Pending shows bits 6 and 7 until each drains.
- AuxReg=0 with AuxValid=1 → accepted, no RegWrite ever issued, Pending unchanged.
- With GRF_WB_STARVE_EN, STARVE_LIMIT=8:
  - Stimulus: continuous pipe writes with one queued entry.
  - PipeStall pulses exactly once, after 8 blocked cycles.
  - The entry writes on the following edge and the counter resets.
